// File: rtl/controle_tentativas_senha.sv
// Password-attempt controller around the 3-bit equality comparator: captures codes on a confirm edge,
// grants a timed unlock window, counts consecutive misses and enforces a timed lockout.
// state | meaning
// IDLE  | waiting for a confirm rising edge
// CMP   | captured codes on comparator pins, fi sampled at end
// GRANT | unlock window running
// DENY  | one-cycle fail pulse
// LOCK  | lockout window running
module controle_tentativas_senha #(
    parameter int MAX_TENT       = 3,
    parameter int GRANT_CYCLES   = 8,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2:0]                    code_in,
    input  logic [2:0]                    stored_code,
    input  logic                          confirm,
    input  logic                          fi,
    output logic                          cmp_a,
    output logic                          cmp_b,
    output logic                          cmp_c,
    output logic                          cmp_d,
    output logic                          cmp_f,
    output logic                          cmp_e,
    output logic                          unlocked,
    output logic                          fail,
    output logic                          locked_out,
    output logic                          busy,
    output logic [$clog2(MAX_TENT+1)-1:0] fail_count
);

    localparam int FCW  = $clog2(MAX_TENT + 1);
    localparam int TMAX = (GRANT_CYCLES > LOCKOUT_CYCLES) ? GRANT_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMP   = 3'd1,
        S_GRANT = 3'd2,
        S_DENY  = 3'd3,
        S_LOCK  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       code_q, code_d;
    logic [2:0]       stored_q, stored_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [FCW-1:0]   fcount_q, fcount_d;
    logic             confirm_q;
    logic             rise;

    assign rise = confirm & ~confirm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            code_q    <= '0;
            stored_q  <= '0;
            timer_q   <= '0;
            fcount_q  <= '0;
            confirm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            stored_q  <= stored_d;
            timer_q   <= timer_d;
            fcount_q  <= fcount_d;
            confirm_q <= confirm;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        stored_d = stored_q;
        timer_d  = timer_q;
        fcount_d = fcount_q;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    code_d   = code_in;
                    stored_d = stored_code;
                    state_d  = S_CMP;
                end
            end
            S_CMP: begin
                if (fi) begin
                    fcount_d = '0;
                    timer_d  = TW'(GRANT_CYCLES - 1);
                    state_d  = S_GRANT;
                end else if (int'(fcount_q) + 1 == MAX_TENT) begin
                    fcount_d = FCW'(MAX_TENT);
                    timer_d  = TW'(LOCKOUT_CYCLES - 1);
                    state_d  = S_LOCK;
                end else begin
                    fcount_d = fcount_q + FCW'(1);
                    state_d  = S_DENY;
                end
            end
            S_GRANT: begin
                if (timer_q == '0) state_d = S_IDLE;
                else               timer_d = timer_q - TW'(1);
            end
            S_DENY: state_d = S_IDLE;
            S_LOCK: begin
                // history is forgiven only once the lockout has fully elapsed
                if (timer_q == '0) begin
                    fcount_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // comparator pairs A-D, B-F, C-E
    assign cmp_a = code_q[2];
    assign cmp_b = code_q[1];
    assign cmp_c = code_q[0];
    assign cmp_d = stored_q[2];
    assign cmp_f = stored_q[1];
    assign cmp_e = stored_q[0];

    assign unlocked   = (state_q == S_GRANT);
    assign fail       = (state_q == S_DENY);
    assign locked_out = (state_q == S_LOCK);
    assign busy       = (state_q != S_IDLE);
    assign fail_count = fcount_q;

endmodule
